regfile_ctrl: RTL and testbench
===============================

REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have parameter: CLEAR_ON_RESET, default 1, meaning 1 = zero x1..x31 after reset and 0 = skip clearing.
REQ-002 SHALL have port: clk  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: wb_valid in 1, wb_addr in 5, wb_data in 32; pipeline write-back request.
REQ-005 SHALL have ports: rd_req in 1, rs1_addr in 5, rs2_addr in 5; pipeline operand read request.
REQ-006 SHALL have ports: rs1_data out 32, rs2_data out 32, rd_valid out 1; operand result.
REQ-007 SHALL have port: busy  out  1  high while clearing; pipeline stalls and issues no requests.
REQ-008 SHALL have ports: rf_wr_en out 1, rf_wr_addr out 5, rf_wr_data out 32; register-file write port.
REQ-009 SHALL have ports: rf_rd_en1 out 1, rf_rd_en2 out 1, rf_rd_addr1 out 5, rf_rd_addr2 out 5; register-file read ports.
REQ-010 SHALL have ports: rf_rs1 in 32, rf_rs2 in 32; register-file read data, valid 1 cycle after the read enable.

Function
REQ-011 SHALL implement FSM states CLEAR and READY.
REQ-012 After reset SHALL enter CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-013 CLEAR SHALL run a 5-bit counter from 1 to 31, one write per cycle: rf_wr_en=1, rf_wr_addr=counter, rf_wr_data=0.
REQ-014 CLEAR SHALL go to READY on the cycle after the write to address 31 (31 write cycles in total); address 0 SHALL never be written.
REQ-015 busy SHALL be 1 exactly while in CLEAR.
REQ-016 In CLEAR, wb_valid and rd_req SHALL be ignored: no write is forwarded, rf_rd_en1/2=0 and rd_valid=0.
REQ-017 In READY, rf_wr_en SHALL equal wb_valid && (wb_addr != 0), with rf_wr_addr=wb_addr and rf_wr_data=wb_data, combinationally.
REQ-018 In READY, rf_rd_en1=rf_rd_en2=rd_req and rf_rd_addr1/2=rs1_addr/rs2_addr, combinationally.
REQ-019 rd_valid SHALL be a one-cycle registered copy of (rd_req && READY), giving 1-cycle read latency.
REQ-020 SHALL register the addresses of each accepted read together with a per-port bypass flag and the cycle's wb_data.
REQ-021 Bypass flag: set when wb_valid && wb_addr == rsN_addr && wb_addr != 0 in the read cycle.
REQ-022 rsN_data when rd_valid=1:
 - 0 if the registered rsN_addr == 0;
 - else the registered wb_data if its bypass flag is set;
 - else rf_rsN.
REQ-023 rsN_data SHALL be 0 when rd_valid=0.
REQ-024 Back-to-back reads every cycle SHALL be supported at full throughput with no bubbles.
REQ-025 rs1_addr == rs2_addr SHALL return identical data on both ports.
REQ-026 A write to x0 SHALL never be forwarded or bypassed.

Reset
REQ-027 rst SHALL have priority over all other inputs.
REQ-028 While rst=1, all outputs SHALL be 0 except busy, which equals CLEAR_ON_RESET.
REQ-029 rst asserted mid-CLEAR SHALL restart the counter at 1.
REQ-030 rst asserted mid-read SHALL drop any pending rd_valid.

Structure
REQ-031 Package rf_pkg SHALL hold XLEN=32, REG_AW=5, NUM_REGS=32 and the state enum {CLEAR, READY}.
REQ-032 The block SHALL be a single module with no sub-modules; it instantiates the register file only at the next level up.

Verification
REQ-033 Reset with CLEAR_ON_RESET=1 -> busy=1 for exactly 31 cycles; writes appear at addresses 1..31 with data 0; then busy=0; a read of x5 returns 0.
REQ-034 Write x3=0xDEADBEEF, then read x3 on the following cycle -> rd_valid 1 cycle later with rs1_data=0xDEADBEEF.
REQ-035 Same cycle: wb x7=0x12345678 and rd_req rs1=7, rs2=7 -> next cycle rs1_data=rs2_data=0x12345678 (bypass).
REQ-036 wb x0=0xFFFFFFFF, same cycle rd_req rs1=0 -> rf_wr_en=0; next cycle rs1_data=0.
REQ-037 Assert rst at CLEAR count 10 for 1 cycle -> clearing restarts at address 1; busy stays high for 31 further cycles.
REQ-038 rd_req and wb_valid asserted during CLEAR -> no rf_rd_en, no rd_valid, and the writes carry only zero data.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths and controller state encoding for the register-file controller.
package rf_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_ctrl.sv
// Register-file front end: zeroes x1..x31 after reset, forwards write-backs,
// and serves two operand reads with one-cycle latency and write-back bypass.
module regfile_ctrl
  import rf_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              rd_req,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_wr_addr,
  output logic [XLEN-1:0]   rf_wr_data,
  output logic              rf_rd_en1,
  output logic              rf_rd_en2,
  output logic [REG_AW-1:0] rf_rd_addr1,
  output logic [REG_AW-1:0] rf_rd_addr2,
  input  logic [XLEN-1:0]   rf_rs1,
  input  logic [XLEN-1:0]   rf_rs2
);

  localparam state_e            RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;
  localparam logic [REG_AW-1:0] LAST_ADDR   = REG_AW'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [REG_AW-1:0] cnt_q, cnt_d;

  logic              rd_valid_q, rd_valid_d;
  logic [REG_AW-1:0] raddr1_q, raddr1_d;
  logic [REG_AW-1:0] raddr2_q, raddr2_d;
  logic              byp1_q, byp1_d;
  logic              byp2_q, byp2_d;
  logic [XLEN-1:0]   wbdata_q, wbdata_d;

  logic              accept;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR:   if (cnt_q == LAST_ADDR) state_d = READY;
      READY:   state_d = READY;
      default: state_d = RESET_STATE;
    endcase
  end

  // Clear counter walks 1..31; it parks at 1 outside CLEAR so a restart is clean.
  always_comb begin
    cnt_d = REG_AW'(1);
    if (state_q == CLEAR) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= REG_AW'(1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Read capture: addresses, bypass flags and the write-back data of the read cycle
  assign accept = !rst && (state_q == READY) && rd_req;

  always_comb begin
    rd_valid_d = accept;
    raddr1_d   = raddr1_q;
    raddr2_d   = raddr2_q;
    byp1_d     = byp1_q;
    byp2_d     = byp2_q;
    wbdata_d   = wbdata_q;
    if (accept) begin
      raddr1_d = rs1_addr;
      raddr2_d = rs2_addr;
      byp1_d   = wb_valid && (wb_addr == rs1_addr) && (wb_addr != '0);
      byp2_d   = wb_valid && (wb_addr == rs2_addr) && (wb_addr != '0);
      wbdata_d = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      raddr1_q   <= '0;
      raddr2_q   <= '0;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      wbdata_q   <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      raddr1_q   <= raddr1_d;
      raddr2_q   <= raddr2_d;
      byp1_q     <= byp1_d;
      byp2_q     <= byp2_d;
      wbdata_q   <= wbdata_d;
    end
  end

  // Output logic; reset forces everything quiet except busy
  always_comb begin
    busy        = (state_q == CLEAR);
    rf_wr_en    = 1'b0;
    rf_wr_addr  = '0;
    rf_wr_data  = '0;
    rf_rd_en1   = 1'b0;
    rf_rd_en2   = 1'b0;
    rf_rd_addr1 = '0;
    rf_rd_addr2 = '0;
    rd_valid    = 1'b0;
    rs1_data    = '0;
    rs2_data    = '0;
    if (rst) begin
      busy = CLEAR_ON_RESET;
    end else begin
      unique case (state_q)
        CLEAR: begin
          rf_wr_en   = 1'b1;
          rf_wr_addr = cnt_q;
          rf_wr_data = '0;
        end
        READY: begin
          rf_wr_en    = wb_valid && (wb_addr != '0);
          rf_wr_addr  = wb_addr;
          rf_wr_data  = wb_data;
          rf_rd_en1   = rd_req;
          rf_rd_en2   = rd_req;
          rf_rd_addr1 = rs1_addr;
          rf_rd_addr2 = rs2_addr;
        end
        default: ;
      endcase
      rd_valid = rd_valid_q;
      if (rd_valid_q) begin
        rs1_data = (raddr1_q == '0) ? '0 : (byp1_q ? wbdata_q : rf_rs1);
        rs2_data = (raddr2_q == '0) ? '0 : (byp2_q ? wbdata_q : rf_rs2);
      end
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: behavioural register file behind the controller,
// architectural shadow model and a scoreboard of expected operand results.
module tb_regfile_ctrl;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rd_req;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        rd_valid, busy;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        rf_rd_en1, rf_rd_en2;
  logic [4:0]  rf_rd_addr1, rf_rd_addr2;
  logic [31:0] rf_rs1, rf_rs2;

  regfile_ctrl #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_req(rd_req), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_valid(rd_valid),
    .busy(busy),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_en1(rf_rd_en1), .rf_rd_en2(rf_rd_en2),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register file: synchronous write, one-cycle registered read
  logic [31:0] rf_mem [32];
  bit          rf_init_done = 1'b0;
  always @(posedge clk) begin
    if (!rf_init_done) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hA5A5_0000 | 32'(i);
      rf_init_done <= 1'b1;
    end else if (rf_wr_en) begin
      rf_mem[rf_wr_addr] <= rf_wr_data;
    end
    if (rf_rd_en1) rf_rs1 <= rf_mem[rf_rd_addr1];
    if (rf_rd_en2) rf_rs2 <= rf_mem[rf_rd_addr2];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    int          due;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } sb_t;
  sb_t         sb [$];
  logic [31:0] model [32];

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    sb_t e;
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rd_latency", 32'(cyc), 32'(e.due));
        check("rs1_data", rs1_data, e.rs1);
        check("rs2_data", rs2_data, e.rs2);
      end
    end else begin
      check("rs1_idle_zero", rs1_data, 32'd0);
      check("rs2_idle_zero", rs2_data, 32'd0);
      if (sb.size() != 0 && sb[0].due <= cyc) begin
        check("missing_rd_valid", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  // Clear sequence while hammering wb/rd inputs; optionally pulse rst after abort_at writes
  task automatic run_clear(input int abort_at, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      wb_valid = 1'b1; wb_addr = 5'(i + 1); wb_data = '1;
      rd_req = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd3;
      #1;
      if (busy !== 1'b1) begin
        wb_valid = 1'b0; rd_req = 1'b0;
        break;
      end
      n++;
      check("clr_we", 32'(rf_wr_en), 32'd1);
      check("clr_addr", 32'(rf_wr_addr), 32'(n));
      check("clr_data", rf_wr_data, 32'd0);
      check("clr_rd_en", 32'({rf_rd_en1, rf_rd_en2}), 32'd0);
      if (abort_at != 0 && n == abort_at) begin
        wb_valid = 1'b0; rd_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_we", 32'(rf_wr_en), 32'd0);
        rst = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rd, input logic [4:0] a1, input logic [4:0] a2,
                       input bit push);
    sb_t e;
    wb_valid = we; wb_addr = wa; wb_data = wd;
    rd_req = rd; rs1_addr = a1; rs2_addr = a2;
    #1;
    check("busy_ready", 32'(busy), 32'd0);
    check("wr_en", 32'(rf_wr_en), 32'(we && wa != 5'd0));
    if (we && wa != 5'd0) begin
      check("wr_addr", 32'(rf_wr_addr), 32'(wa));
      check("wr_data", rf_wr_data, wd);
    end
    check("rd_en", 32'({rf_rd_en1, rf_rd_en2}), rd ? 32'd3 : 32'd0);
    if (rd) begin
      check("rd_addr", 32'({rf_rd_addr1, rf_rd_addr2}), 32'({a1, a2}));
    end
    if (rd && push) begin
      e.due = cyc + 1;
      e.rs1 = (a1 == 5'd0) ? 32'd0 : ((we && wa == a1) ? wd : model[a1]);
      e.rs2 = (a2 == 5'd0) ? 32'd0 : ((we && wa == a2) ? wd : model[a2]);
      sb.push_back(e);
    end
    if (we && wa != 5'd0) model[wa] = wd;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic        we, rd;
    logic [4:0]  wa, a1, a2;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset with live requests: everything quiet except busy
    rst = 1'b1; wb_valid = 1'b1; wb_addr = 5'd4; wb_data = '1;
    rd_req = 1'b1; rs1_addr = 5'd4; rs2_addr = 5'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_we", 32'(rf_wr_en), 32'd0);
    check("reset_rd_en", 32'({rf_rd_en1, rf_rd_en2}), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    rst = 1'b0;

    // Partial clear, reset at count 10, then the full 31-cycle clear
    run_clear(10, n);
    check("abort_count", 32'(n), 32'd10);
    run_clear(0, n);
    check("clear_len", 32'(n), 32'd31);

    issue(1'b0, 5'd0, '0, 1'b1, 5'd5, 5'd31, 1'b1);
    issue(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b1);
    issue(1'b0, 5'd0, '0, 1'b1, 5'd3, 5'd0, 1'b1);
    issue(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 5'd7, 1'b1);
    issue(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd3, 1'b1);
    issue(1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd3, 1'b1);

    // Back-to-back random traffic on a small address window for frequent bypass hits
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 7));
      rd = ($urandom_range(0, 3) != 0);
      a1 = 5'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 7));
      issue(we, wa, $urandom, rd, a1, a2, 1'b1);
    end
    issue(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 1'b1);
    issue(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 1'b1);

    // Reset right after an accepted read must swallow its rd_valid
    issue(1'b0, 5'd0, '0, 1'b1, 5'd3, 5'd7, 1'b0);
    rd_req = 1'b0; rst = 1'b1;
    #1;
    check("rst_drop_valid", 32'(rd_valid), 32'd0);
    check("rst_drop_data", rs1_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_clear(0, n);
    check("clear_len_2", 32'(n), 32'd31);
    @(posedge clk); #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
